// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable N-bit serial pattern detector
// Registered Moore hit pulse, saturating hit counter, optional overlapping matches.
module seq_detector_param #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b010,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     _rst,
  input  logic                     en,
  input  logic                     D,
  input  logic                     pat_load,
  input  logic [N-1:0]             pat_in,
  input  logic                     clr,
  output logic                     Q,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [$clog2(N+1)-1:0]   fill
);

  localparam int             FW       = $clog2(N+1);
  localparam logic [FW-1:0]  FULL     = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {FILLING = 1'b0, ARMED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     win_q, win_d;
  logic [N-1:0]     pat_q, pat_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             m_q, m_d;
  logic             q_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     win_shift;
  logic [FW-1:0]    fill_inc;
  logic             hit;

  // Waveform aid: readable state name.
  logic [55:0]      state_name;

  always_comb begin
    state_name = (state_q == ARMED) ? "ARMED  " : "FILLING";
  end

  always_comb begin
    win_shift = {win_q[N-2:0], D};
    fill_inc  = (state_q == ARMED) ? FULL : fill_q + 1'b1;
    hit       = (win_shift == pat_q) && (fill_inc == FULL);

    win_d   = win_q;
    pat_d   = pat_q;
    fill_d  = fill_q;
    m_d     = 1'b0;
    state_d = state_q;

    if (pat_load) begin
      pat_d   = pat_in;
      fill_d  = '0;
      state_d = FILLING;
    end else if (en) begin
      win_d  = win_shift;
      fill_d = fill_inc;
      m_d    = hit;
      // Non-overlapping mode discards the matched bits on the same edge.
      if (hit && !OVERLAP) begin
        fill_d = '0;
      end
      state_d = (fill_d == FULL) ? ARMED : FILLING;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (m_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q <= FILLING;
      win_q   <= '0;
      pat_q   <= PATTERN;
      fill_q  <= '0;
      m_q     <= 1'b0;
      q_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      m_q     <= m_d;
      q_q     <= m_q;
      cnt_q   <= cnt_d;
    end
  end

  assign Q       = q_q;
  assign hit_cnt = cnt_q;
  assign fill    = fill_q;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector, successor to the fixed 3-bit Moore sequence detectors in the lab set.
- Matches a programmable N-bit pattern on a 1-bit serial input D, sampled under an enable.
- Supports overlapping and non-overlapping detection.
- Output is a registered Moore-style hit pulse, plus a saturating hit counter for the checking logic.

Parameters:
N, 3, pattern length in bits (N >= 2)
PATTERN, 3'b010, reset value of the pattern register; bit N-1 is the first bit received, bit 0 the last
OVERLAP, 1, 1 = overlapping matches allowed; 0 = the window restarts empty after each match
CNT_W, 8, width of hit counter

Ports:
clk  input  1  clock, rising edge
_rst  input  1  asynchronous active-low reset
en  input  1  sample enable; D is consumed only on edges where en=1
D  input  1  serial data bit
pat_load  input  1  load pat_in into the pattern register
pat_in  input  N  new pattern, same bit order as PATTERN
clr  input  1  synchronous clear of hit_cnt
Q  output  1  registered hit pulse
hit_cnt  output  CNT_W  saturating count of matches
fill  output  clog2(N+1)  number of valid bits in the window, 0..N

Behaviour:
- Reset is _rst low, asynchronous, active-low; clock is clk.
- Reset values:
  - Window (N bits) = 0; fill = 0; internal match flag m = 0.
  - Q = 0; hit_cnt = 0; pattern register = PATTERN.
- Priority on each rising edge: pat_load > en sample.
- pat_load = 1:
  - pattern register <= pat_in; window fill <= 0; m <= 0.
  - D is ignored that cycle, even if en = 1.
- en = 1 and pat_load = 0:
  - window <= {window[N-2:0], D}.
  - fill <= min(fill+1, N).
  - m <= 1 iff the updated window equals the pattern and the updated fill == N; otherwise m <= 0.
- en = 0 and pat_load = 0: window and fill hold; m <= 0.
- After a match (m set):
  - OVERLAP = 1: window and fill are unchanged, so bits can be shared between matches (010 then 10 detects again).
  - OVERLAP = 0: fill is forced to 0 on the same edge that sets m, and the next match needs N fresh bits.
- Q <= m on every edge.
  - Latency: last pattern bit sampled at edge k, m = 1 after edge k, Q = 1 for the cycle after edge k+1.
  - Q is high for exactly one cycle per match.
  - Back-to-back matches (e.g. pattern 111 on a stream of 1s with OVERLAP = 1) give Q high on consecutive cycles.
- hit_cnt:
  - Increments by 1 on each edge where m = 1, i.e. the count tracks Q one cycle early.
  - Saturates at 2^CNT_W - 1.
  - clr = 1 forces hit_cnt to 0; clr wins over a simultaneous increment, and that hit is not counted.
  - clr does not affect window, fill, m or Q.
- Reset mid-operation: all state clears immediately (asynchronous), including a pending Q. Detection restarts requiring N new enabled bits.
- Internal FSM:
  - States FILLING (fill < N) and ARMED (fill == N).
  - FILLING goes to ARMED when N bits have been gathered.
  - ARMED goes to FILLING on pat_load, or on a match when OVERLAP = 0.
  - A text state name register is provided for simulation waveforms.
- All outputs are driven from flops; there are no combinational paths from inputs to outputs.

Test Plan:
1. N=3, PATTERN=010, OVERLAP=1, en=1, D stream 0,1,0,1,0 on edges 1..5 -> Q high after edges 4 and 6; hit_cnt=2; fill stays 3 from edge 3 on.
2. Same stream with OVERLAP=0 -> Q high only after edge 4; hit_cnt=1; fill goes 1,2,0,1,2.
3. en gaps: D 0 (en=1), X (en=0, two cycles), 1 (en=1), 0 (en=1) -> exactly one Q pulse, one cycle after the edge following the final 0; Q=0 during the gap cycles.
4. pat_load with pat_in=3'b110 while the window holds 01 -> fill=0; stream 1,1,0 -> one Q pulse; an old-pattern stream 0,1,0 -> no pulse.
5. CNT_W=2, OVERLAP=1, pattern 111, D=1 for 7 enabled cycles -> Q high for 5 consecutive cycles; hit_cnt saturates at 3. Then clr with a simultaneous match -> hit_cnt=0.
6. Assert _rst low mid-cycle right after m=1 (between edges) -> Q, hit_cnt and fill go to 0 immediately with no pulse after release; pattern register returns to 010.
